// File: rtl/div_pkg.sv
// Shared width, latency and per-stage record for the pipelined restoring divider.
package div_pkg;

    localparam int W = 32;

    function automatic int latency(input int w);
        return w + 2;
    endfunction

    localparam int LATENCY = latency(W);

    typedef struct packed {
        logic         valid;
        logic         neg_q;
        logic         neg_r;
        logic         div0;
        logic [W-1:0] a_sh;
        logic [W-1:0] b_mag;
        logic [W:0]   rem;
        logic [W-1:0] q;
    } stage_t;

endpackage

// File: rtl/div_stage.sv
// One restoring division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, record the quotient bit, then register the record.
module div_stage
    import div_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  stage_t prev,
    output stage_t next
);

    stage_t       nxt;
    logic [W:0]   rem_sh;
    logic [W+1:0] diff;
    logic         borrow;
    logic         unused_rem_msb;

    // Partial remainder stays below |b| <= 2^(W-1), so its top bit is always clear.
    assign unused_rem_msb = prev.rem[W];

    always_comb begin
        rem_sh   = {prev.rem[W-1:0], prev.a_sh[W-1]};
        diff     = {1'b0, rem_sh} - {2'b00, prev.b_mag};
        borrow   = diff[W+1];
        nxt      = prev;
        nxt.a_sh = {prev.a_sh[W-2:0], 1'b0};
        nxt.rem  = borrow ? rem_sh : diff[W:0];
        nxt.q    = {prev.q[W-2:0], ~borrow};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            next <= '0;
        end else begin
            next <= nxt;
        end
    end

endmodule

// File: rtl/div32_pipe.sv
// Fully pipelined signed divider: magnitude/sign capture, W restoring stages,
// and a sign-fix output register. One operation accepted per clock.
module div32_pipe
    import div_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         rfd,
    output logic [W-1:0] quotient,
    output logic [W-1:0] fractional
);

    stage_t s_in;
    stage_t pipe [1:W];
    logic   unused_tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            rfd  <= 1'b0;
            s_in <= '0;
        end else begin
            rfd         <= 1'b1;
            s_in.valid  <= rfd;
            s_in.neg_q  <= dividend[W-1] ^ divisor[W-1];
            s_in.neg_r  <= dividend[W-1];
            s_in.div0   <= (divisor == '0);
            // Negating the most negative value wraps to itself, which reads correctly as unsigned 2^(W-1).
            s_in.a_sh   <= dividend[W-1] ? -dividend : dividend;
            s_in.b_mag  <= divisor[W-1] ? -divisor : divisor;
            s_in.rem    <= '0;
            s_in.q      <= '0;
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_stage
        if (i == 0) begin : g_first
            div_stage u_stage (
                .clk  (clk),
                .rst  (rst),
                .prev (s_in),
                .next (pipe[1])
            );
        end else begin : g_rest
            div_stage u_stage (
                .clk  (clk),
                .rst  (rst),
                .prev (pipe[i]),
                .next (pipe[i+1])
            );
        end
    end

    assign unused_tail = ^{pipe[W].a_sh, pipe[W].b_mag, pipe[W].rem[W]};

    // Divide-by-zero leaves the all-ones quotient unsigned; the remainder then equals the dividend.
    always_ff @(posedge clk) begin
        if (rst || !pipe[W].valid) begin
            quotient   <= '0;
            fractional <= '0;
        end else begin
            quotient   <= (pipe[W].neg_q && !pipe[W].div0) ? -pipe[W].q : pipe[W].q;
            fractional <= pipe[W].neg_r ? -pipe[W].rem[W-1:0] : pipe[W].rem[W-1:0];
        end
    end

endmodule

// File: tb/tb_div32_pipe.sv
// Directed and streamed checks for div32_pipe: reset, sign handling, special
// cases, back-to-back throughput and reset while operations are in flight.
module tb_div32_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = 32'd1;
    logic        rfd;
    logic [31:0] quotient;
    logic [31:0] fractional;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div32_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .dividend   (dividend),
        .divisor    (divisor),
        .rfd        (rfd),
        .quotient   (quotient),
        .fractional (fractional)
    );

    function automatic logic [31:0] model_q(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
    endfunction

    function automatic logic [31:0] model_r(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        dividend = 32'd1;
        divisor = 32'd1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (rfd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rfd: got %b, expected 0", rfd);
        end
        n_checks++;
        if (quotient !== 32'd0 || fractional !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: q=%h frac=%h, expected 0/0", quotient, fractional);
        end
        rst = 1'b0;
        for (int t = 1; t <= 35; t++) begin
            @(negedge clk);
            if (t == 1) begin
                n_checks++;
                if (rfd !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rfd_rise: got %b, expected 1", rfd);
                end
            end
            n_checks++;
            if (t < 35) begin
                if (quotient !== 32'd0 || fractional !== 32'd0) begin
                    n_fail++;
                    $display("FAIL first_latency[%0d]: q=%h frac=%h, expected 0/0", t, quotient, fractional);
                end
            end else begin
                if (quotient !== 32'd1 || fractional !== 32'd0) begin
                    n_fail++;
                    $display("FAIL first_result: q=%h frac=%h, expected 1/0", quotient, fractional);
                end
            end
        end
    endtask

    task automatic test_signs();
        logic [31:0] va [4] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C};
        logic [31:0] vb [4] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] vq [4] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14};
        logic [31:0] vr [4] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFE};
        for (int t = 0; t < 4 + 34; t++) begin
            @(negedge clk);
            if (t >= 34) begin
                n_checks++;
                if (quotient !== vq[t-34] || fractional !== vr[t-34]) begin
                    n_fail++;
                    $display("FAIL signs[%0d]: q=%h frac=%h, expected q=%h frac=%h",
                             t - 34, quotient, fractional, vq[t-34], vr[t-34]);
                end
            end
            if (t < 4) begin
                dividend = va[t];
                divisor = vb[t];
            end else begin
                dividend = '0;
                divisor = 32'd1;
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] va [4] = '{32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'd0};
        logic [31:0] vb [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd5};
        logic [31:0] vq [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        logic [31:0] vr [4] = '{32'd7, 32'hFFFF_FFF9, 32'd0, 32'd0};
        for (int t = 0; t < 4 + 34; t++) begin
            @(negedge clk);
            if (t >= 34) begin
                n_checks++;
                if (quotient !== vq[t-34] || fractional !== vr[t-34]) begin
                    n_fail++;
                    $display("FAIL special[%0d]: q=%h frac=%h, expected q=%h frac=%h",
                             t - 34, quotient, fractional, vq[t-34], vr[t-34]);
                end
            end
            if (t < 4) begin
                dividend = va[t];
                divisor = vb[t];
            end else begin
                dividend = '0;
                divisor = 32'd1;
            end
        end
    endtask

    task automatic test_extremes();
        logic [31:0] va [5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] vb [5] = '{32'd1, 32'd2, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] vq [5] = '{32'h7FFF_FFFF, 32'hC000_0000, 32'd0, 32'd1, 32'd0};
        logic [31:0] vr [5] = '{32'd0, 32'd0, 32'd5, 32'd0, 32'h7FFF_FFFF};
        for (int t = 0; t < 5 + 34; t++) begin
            @(negedge clk);
            if (t >= 34) begin
                n_checks++;
                if (quotient !== vq[t-34] || fractional !== vr[t-34]) begin
                    n_fail++;
                    $display("FAIL extremes[%0d]: q=%h frac=%h, expected q=%h frac=%h",
                             t - 34, quotient, fractional, vq[t-34], vr[t-34]);
                end
            end
            if (t < 5) begin
                dividend = va[t];
                divisor = vb[t];
            end else begin
                dividend = '0;
                divisor = 32'd1;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ra [40];
        logic [31:0] rb [40];
        logic [31:0] eq [40];
        logic [31:0] er [40];
        for (int i = 0; i < 40; i++) begin
            ra[i] = $urandom;
            case (i % 4)
                0: rb[i] = $urandom;
                1: rb[i] = 32'($urandom_range(1, 300));
                2: rb[i] = -32'($urandom_range(1, 300));
                default: rb[i] = $urandom >> $urandom_range(0, 30);
            endcase
            eq[i] = model_q(ra[i], rb[i]);
            er[i] = model_r(ra[i], rb[i]);
        end
        for (int t = 0; t < 40 + 34; t++) begin
            @(negedge clk);
            if (t >= 34) begin
                n_checks++;
                if (quotient !== eq[t-34] || fractional !== er[t-34]) begin
                    n_fail++;
                    $display("FAIL stream[%0d] %h/%h: q=%h frac=%h, expected q=%h frac=%h",
                             t - 34, ra[t-34], rb[t-34], quotient, fractional, eq[t-34], er[t-34]);
                end
            end
            if (t < 40) begin
                dividend = ra[t];
                divisor = rb[t];
            end else begin
                dividend = '0;
                divisor = 32'd1;
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] va [3] = '{32'd1000, 32'hFFFF_FC18, 32'd12345};
        logic [31:0] vb [3] = '{32'd3, 32'd3, 32'd100};
        logic [31:0] vq [3] = '{32'd333, 32'hFFFF_FEB3, 32'd123};
        logic [31:0] vr [3] = '{32'd1, 32'hFFFF_FFFF, 32'd45};
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            dividend = $urandom;
            divisor = 32'($urandom_range(1, 50));
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rfd !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_rfd_low: got %b, expected 0", rfd);
        end
        rst = 1'b0;
        for (int u = 0; u < 38; u++) begin
            if (u > 0) @(negedge clk);
            if (u == 1) begin
                n_checks++;
                if (rfd !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midreset_rfd_high: got %b, expected 1", rfd);
                end
            end
            n_checks++;
            if (u <= 34) begin
                if (quotient !== 32'd0 || fractional !== 32'd0) begin
                    n_fail++;
                    $display("FAIL midreset_flush[%0d]: q=%h frac=%h, expected 0/0", u, quotient, fractional);
                end
            end else begin
                if (quotient !== vq[u-35] || fractional !== vr[u-35]) begin
                    n_fail++;
                    $display("FAIL midreset_result[%0d]: q=%h frac=%h, expected q=%h frac=%h",
                             u - 35, quotient, fractional, vq[u-35], vr[u-35]);
                end
            end
            if (u == 0) begin
                dividend = 32'd77;
                divisor = 32'd5;
            end else if (u <= 3) begin
                dividend = va[u-1];
                divisor = vb[u-1];
            end else begin
                dividend = '0;
                divisor = 32'd1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_signs();
        test_special();
        test_extremes();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
